ldtu_ser_rx_align: RTL

//  Receive end of one LiTE-DTU serializer lane: samples the serial stream at the serializer bit clock and

---
 rtl/ldtu_rx_pkg.sv | 13 +
 rtl/ldtu_ser_rx_align_if.sv | 28 ++
 rtl/ldtu_rx_lock_fsm.sv | 110 +++++++++++
 rtl/ldtu_ser_rx_align.sv | 93 +++++++++
 4 files changed

// File: rtl/ldtu_rx_pkg.sv
// Shared types and defaults for the LiTE-DTU serializer lane receiver.
package ldtu_rx_pkg;

  localparam int unsigned DEFAULT_NBITS = 32;
  localparam logic [DEFAULT_NBITS-1:0] DEFAULT_SYNC_PATTERN = 32'h5A5A_F00F;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ldtu_ser_rx_align_if.sv
// Lane-side bundle of the serial receiver: serial input/controls towards the aligner, recovered words back.
interface ldtu_ser_rx_align_if
  import ldtu_rx_pkg::*;
#(
  parameter int unsigned NBITS = DEFAULT_NBITS
);

  logic             ser_in;
  logic             sync_mode;
  logic [NBITS-1:0] sync_pattern;
  logic             resync;
  logic [NBITS-1:0] data_out;
  logic             data_valid;
  logic             locked;
  logic             align_err;
  logic [7:0]       lock_lost_cnt;

  modport master (
    output ser_in, sync_mode, sync_pattern, resync,
    input  data_out, data_valid, locked, align_err, lock_lost_cnt
  );

  modport slave (
    input  ser_in, sync_mode, sync_pattern, resync,
    output data_out, data_valid, locked, align_err, lock_lost_cnt
  );

endinterface

// File: rtl/ldtu_rx_lock_fsm.sv
// Word-alignment lock tracker: hunt for the sync word, verify it on LOCK_CNT boundaries, drop on UNLOCK_CNT bad ones.
module ldtu_rx_lock_fsm
  import ldtu_rx_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic clock,
  input  logic rst_b,
  input  logic boundary,
  input  logic match,
  input  logic syncMode,
  input  logic resync,
  output logic locked,
  output logic alignErr,
  output logic restartPhase_c,
  output logic emit_c,
  output logic lockLost_c
);

  rx_state_t        state, stateNext;
  logic [CNT_W-1:0] okCnt, okNext;
  logic [CNT_W-1:0] badCnt, badNext;
  logic             alignErrNext;

  // Next-state and strobe decode; resync overrides every transition.
  always_comb begin
    stateNext      = state;
    okNext         = okCnt;
    badNext        = badCnt;
    alignErrNext   = 1'b0;
    restartPhase_c = 1'b0;
    emit_c         = 1'b0;
    lockLost_c     = 1'b0;
    if (resync) begin
      stateNext = HUNT;
      okNext    = '0;
      badNext   = '0;
    end else begin
      case (state)
        HUNT: begin
          if (match) begin
            restartPhase_c = 1'b1;
            if (LOCK_CNT == 1) begin
              stateNext = LOCKED;
              okNext    = '0;
            end else begin
              stateNext = VERIFY;
              okNext    = CNT_W'(1);
            end
            badNext = '0;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (!match) begin
              stateNext = HUNT;
              okNext    = '0;
            end else if (okCnt == CNT_W'(LOCK_CNT - 1)) begin
              stateNext = LOCKED;
              okNext    = '0;
            end else begin
              okNext = okCnt + CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            emit_c = 1'b1;
            if (syncMode && !match) begin
              alignErrNext = 1'b1;
              if (badCnt == CNT_W'(UNLOCK_CNT - 1)) begin
                stateNext  = HUNT;
                badNext    = '0;
                lockLost_c = 1'b1;
              end else begin
                badNext = badCnt + CNT_W'(1);
              end
            end else begin
              badNext = '0;
            end
          end
        end
        default: begin
          stateNext = HUNT;
          okNext    = '0;
          badNext   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      state    <= HUNT;
      okCnt    <= '0;
      badCnt   <= '0;
      locked   <= 1'b0;
      alignErr <= 1'b0;
    end else begin
      state    <= stateNext;
      okCnt    <= okNext;
      badCnt   <= badNext;
      locked   <= (stateNext == LOCKED);
      alignErr <= alignErrNext;
    end
  end

endmodule

// File: rtl/ldtu_ser_rx_align.sv
// Receive end of one LiTE-DTU serializer lane: deserializes the bit stream and aligns it to the sync word.
module ldtu_ser_rx_align
  import ldtu_rx_pkg::*;
#(
  parameter int unsigned NBITS      = DEFAULT_NBITS,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 3
) (
  input logic              clock,
  input logic              rst_b,
  ldtu_ser_rx_align_if.slave rx
);

  localparam int unsigned BIT_W  = $clog2(NBITS);
  localparam int unsigned LOST_W = 8;

  // Only NBITS-1 history bits are stored; the newest bit comes straight from ser_in.
  logic [NBITS-2:0]  sh;
  logic [NBITS-1:0]  shNext;
  logic [BIT_W-1:0]  bitCnt;
  logic [NBITS-1:0]  dataOut;
  logic              dataValid;
  logic [LOST_W-1:0] lockLostCnt;
  logic              boundary;
  logic              match;
  logic              fsmLocked;
  logic              fsmAlignErr;
  logic              restartPhase_c;
  logic              emit_c;
  logic              lockLost_c;

  assign shNext   = {sh, rx.ser_in};
  assign match    = (shNext == rx.sync_pattern);
  assign boundary = (bitCnt == BIT_W'(NBITS - 1));

  ldtu_rx_lock_fsm #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .CNT_W      (CNT_W)
  ) u_lockFsm (
    .clock          (clock),
    .rst_b          (rst_b),
    .boundary       (boundary),
    .match          (match),
    .syncMode       (rx.sync_mode),
    .resync         (rx.resync),
    .locked         (fsmLocked),
    .alignErr       (fsmAlignErr),
    .restartPhase_c (restartPhase_c),
    .emit_c         (emit_c),
    .lockLost_c     (lockLost_c)
  );

  // Shift register and word-phase counter; a hunt match makes the next bit the first of a word.
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      sh     <= '0;
      bitCnt <= '0;
    end else begin
      sh <= shNext[NBITS-2:0];
      if (restartPhase_c || boundary) begin
        bitCnt <= '0;
      end else begin
        bitCnt <= bitCnt + BIT_W'(1);
      end
    end
  end

  // Recovered word, valid strobe and saturating lock-loss counter.
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      dataOut     <= '0;
      dataValid   <= 1'b0;
      lockLostCnt <= '0;
    end else begin
      dataValid <= emit_c;
      if (emit_c) begin
        dataOut <= shNext;
      end
      if (lockLost_c && (lockLostCnt != {LOST_W{1'b1}})) begin
        lockLostCnt <= lockLostCnt + LOST_W'(1);
      end
    end
  end

  assign rx.data_out      = dataOut;
  assign rx.data_valid    = dataValid;
  assign rx.locked        = fsmLocked;
  assign rx.align_err     = fsmAlignErr;
  assign rx.lock_lost_cnt = lockLostCnt;

endmodule
